rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 105 ++++++++++
 tb/tb_rr_arbiter_4.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and a bounded hold time.
// A grant held for MAX_HOLD cycles is revoked, and a one-cycle timeout pulse follows.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic       timeout_q, timeout_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Search last+1, last+2, last+3, then last itself (lowest priority).
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    last_d      = last_q;
    hold_d      = hold_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StGrant;
          gnt_d       = 4'b0001 << win_idx;
          gnt_id_d    = win_idx;
          gnt_valid_d = 1'b1;
          last_d      = win_idx;
          hold_d      = 8'd1;
        end
      end
      StGrant: begin
        if (req[gnt_id_q] && (hold_q < MaxHold)) begin
          hold_d = hold_q + 8'd1;
        end else begin
          // Voluntary release or hold expiry; only expiry raises timeout.
          state_d     = StIdle;
          gnt_d       = 4'b0000;
          gnt_valid_d = 1'b0;
          hold_d      = 8'd0;
          timeout_d   = req[gnt_id_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= 4'b0000;
      gnt_id_q    <= 2'b00;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 2'd3;
      hold_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4: expected grant/timeout per cycle are queued as each
// request pattern is driven and compared after the following clock edge.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_assert;
  int n_fail;

  logic [4:0] exp_q[$];

  rr_arbiter_4 #(
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // Drive one request pattern, then compare the outputs seen after the next edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic et);
    logic [4:0] e;
    req = r;
    exp_q.push_back({eg, et});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      chk("gnt", gnt, e[4:1]);
      chk("timeout", {3'b000, timeout}, {3'b000, e[0]});
      chk("gnt_valid", {3'b000, gnt_valid}, {3'b000, |e[4:1]});
      if (|e[4:1]) chk("gnt_id", {2'b00, gnt_id}, {2'b00, idx_of(e[4:1])});
    end
  endtask

  // Structural invariants, checked every cycle away from the active edge.
  always @(negedge clk) begin
    chk("gnt_onehot0", {3'b000, $onehot0(gnt)}, 4'b0001);
    chk("valid_vs_gnt", {3'b000, gnt_valid}, {3'b000, |gnt});
    if (gnt_valid) chk("id_vs_gnt", gnt, 4'b0001 << gnt_id);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    #23;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_gnt_id", {2'b00, gnt_id}, 4'b0000);
    chk("rst_valid", {3'b000, gnt_valid}, 4'b0000);
    chk("rst_timeout", {3'b000, timeout}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Basic grant, hold three cycles, drop, next requester wins.
    step(4'b1111, 4'b0001, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1111, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Last winner 1: index 3 beats index 0, then 0 wins.
    step(4'b1001, 4'b1000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1001, 4'b0001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Sole requester 2 held 20 cycles: timeout, idle, re-grant.
    for (int c = 0; c < 8; c++) step(4'b0100, 4'b0100, 1'b0);
    step(4'b0100, 4'b0000, 1'b1);
    for (int c = 0; c < 8; c++) step(4'b0100, 4'b0100, 1'b0);
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Reset mid-grant drops the grant without an edge.
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", gnt, 4'b0000);
    chk("async_rst_valid", {3'b000, gnt_valid}, 4'b0000);
    chk("async_rst_timeout", {3'b000, timeout}, 4'b0000);
    @(posedge clk);
    #1;
    chk("held_rst_gnt", gnt, 4'b0000);
    chk("held_rst_timeout", {3'b000, timeout}, 4'b0000);
    rst = 1'b0;
    step(4'b0110, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Fresh reset, then full rotation under continuous requests.
    rst = 1'b1;
    #3;
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) step(4'b1111, 4'b0001 << (g % 4), 1'b0);
      step(4'b1111, 4'b0000, 1'b1);
    end
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
